// File: rtl/data_serializer_pkg.sv
// Shared types and defaults for the block-to-beat serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_serializer_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int BEAT_W_DEF = 8;
  localparam int NBEATS_DEF = DATA_W_DEF / BEAT_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat counter width; a single-beat block still gets a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_serializer_cnt.sv
// Modulo-N beat counter with enable, clear and terminal-count output.
// Latency: count updates one cycle after en/clr; tc is decoded from the count.
// Backpressure: none; holds its value whenever en is low.
module data_serializer_cnt #(
  parameter int N  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Count accepted beats, wrapping after N; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/data_serializer.sv
// Streams a parallel DATA_W block out as DATA_W/BEAT_W beats, MSB beat first.
// Latency: first beat valid the cycle after load; tx_done the cycle after the last accept.
// Backpressure: tx_ready low stalls with tx_data/tx_last held; load_ready is low while sending.
module data_serializer
  import data_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] data_reg_out,
  output logic [BEAT_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              tx_done,
  output logic              busy
);

  // DATA_W must be an exact multiple of BEAT_W.
  localparam int NBEATS = DATA_W / BEAT_W;
  localparam int CW     = cnt_width(NBEATS);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              cnt_tc;
  logic              done_q;
  logic              load_fire;
  logic              beat_fire;
  logic              last_fire;

  // Handshakes are qualified by registered state only, so no input reaches an output.
  assign load_fire = load_valid && (state_q == IDLE);
  assign beat_fire = tx_ready && (state_q == SEND);
  assign last_fire = beat_fire && cnt_tc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: take a block in IDLE, return to IDLE once the final beat is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_valid) state_d = SEND;
      SEND:    if (tx_ready && cnt_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the block on load, then shift one beat out per accept with zero fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load_fire) begin
      shreg <= data_reg_out;
    end else if (beat_fire) begin
      shreg <= shreg << BEAT_W;
    end
  end

  // Single-cycle completion pulse following the final accept; a reset cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_fire;
    end
  end

  data_serializer_cnt #(
    .N  (NBEATS),
    .CW (CW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (beat_fire),
    .clr (load_fire || last_fire),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  assign load_ready = (state_q == IDLE);
  assign tx_valid   = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign tx_data    = shreg[DATA_W-1 -: BEAT_W];
  assign tx_last    = (state_q == SEND) && cnt_tc;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_data_serializer.sv
// Bench for data_serializer: cycle tables, scoreboard of expected beats, corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_serializer;

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] BLK_C = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] BLK_D = 128'hA5A5A5A55A5A5A5A123456789ABCDEF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [127:0] data_reg_out = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         tx_last;
  logic         tx_done;
  logic         busy;

  logic         w_load_valid = 1'b0;
  logic         w_load_ready;
  logic [127:0] w_data = '0;
  logic [31:0]  w_tx_data;
  logic         w_tx_valid;
  logic         w_tx_ready = 1'b0;
  logic         w_tx_last;
  logic         w_tx_done;
  logic         w_busy;

  data_serializer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .data_reg_out(data_reg_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .tx_done(tx_done), .busy(busy)
  );

  data_serializer #(.DATA_W(128), .BEAT_W(32)) dut_w (
    .clk(clk), .rst(rst), .load_valid(w_load_valid), .load_ready(w_load_ready),
    .data_reg_out(w_data), .tx_data(w_tx_data), .tx_valid(w_tx_valid),
    .tx_ready(w_tx_ready), .tx_last(w_tx_last), .tx_done(w_tx_done), .busy(w_busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } beat_t;
  beat_t sbq[$];

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [7:0] dat;
    logic       last;
    logic       done;
    logic       lrdy;
  } vec_t;
  vec_t tbl[32];
  int   tbl_n;

  logic       exp_done = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = '0;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor at the falling edge: scoreboard, stall stability, done pulse.
  task automatic mon();
    beat_t e;
    logic  nd;
    if (rst) begin
      sbq.delete();
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("tx_done_pulse", tx_done, exp_done);
      chk("busy_eq_valid", busy, tx_valid);
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_dat);
        chk("stall_last", tx_last, prev_last);
      end
      nd = 1'b0;
      if (tx_valid && tx_ready) begin
        chk("beat_expected", (sbq.size() > 0) ? 1 : 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("beat_data", tx_data, e.dat);
          chk("beat_last", tx_last, e.last);
          nd = e.last;
        end
      end
      exp_done   = nd;
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
      prev_last  = tx_last;
      if (load_valid && load_ready) begin
        for (int i = 0; i < 16; i++) begin
          e.dat  = data_reg_out[127 - 8*i -: 8];
          e.last = (i == 15);
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    mon();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      settle();
      if (sbq.size() == 0 && !tx_valid && !tx_done) ok = 1;
      edge_();
      if (ok) break;
    end
    chk("drain_timeout", ok, 1);
  endtask

  // Expected cycle-by-cycle outputs for BLK_A, optionally stalling one beat.
  task automatic fill_tbl(input int stall_at, input int stall_len);
    vec_t v;
    int   s = stall_len;
    tbl_n = 0;
    for (int b = 0; b < 16;) begin
      v.vld  = 1'b1;
      v.dat  = {b[3:0], b[3:0]};
      v.last = (b == 15);
      v.done = 1'b0;
      v.lrdy = 1'b0;
      if (b == stall_at && s > 0) begin
        v.rdy = 1'b0;
        s--;
      end else begin
        v.rdy = 1'b1;
        b++;
      end
      tbl[tbl_n] = v;
      tbl_n++;
    end
    v.rdy = 1'b1; v.vld = 1'b0; v.dat = 8'h00; v.last = 1'b0; v.done = 1'b1; v.lrdy = 1'b1;
    tbl[tbl_n] = v;
    tbl_n++;
  endtask

  task automatic run_tbl(input string tag);
    load_valid   = 1'b1;
    data_reg_out = BLK_A;
    tx_ready     = 1'b0;
    settle();
    chk({tag, "_load_ready"}, load_ready, 1);
    edge_();
    load_valid = 1'b0;
    for (int i = 0; i < tbl_n; i++) begin
      tx_ready = tbl[i].rdy;
      settle();
      chk($sformatf("%s_vld_c%0d", tag, i + 1), tx_valid, tbl[i].vld);
      chk($sformatf("%s_dat_c%0d", tag, i + 1), tx_data, tbl[i].dat);
      chk($sformatf("%s_last_c%0d", tag, i + 1), tx_last, tbl[i].last);
      chk($sformatf("%s_done_c%0d", tag, i + 1), tx_done, tbl[i].done);
      chk($sformatf("%s_lrdy_c%0d", tag, i + 1), load_ready, tbl[i].lrdy);
      edge_();
    end
    tx_ready = 1'b0;
  endtask

  task automatic load_blk(input logic [127:0] blk);
    load_valid   = 1'b1;
    data_reg_out = blk;
    settle();
    chk("load_ready_idle", load_ready, 1);
    edge_();
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wexp[4];
    bit          got;
    wexp[0] = 32'h00112233; wexp[1] = 32'h44556677;
    wexp[2] = 32'h8899AABB; wexp[3] = 32'hCCDDEEFF;

    // Reset values.
    edge_();
    edge_();
    rst = 1'b0;
    settle();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    edge_();

    // Streaming with ready held high, then with a 3-cycle stall on beat 0x44.
    fill_tbl(-1, 0);
    run_tbl("flow");
    fill_tbl(4, 3);
    run_tbl("stall");
    wait_idle(10);

    // Back-to-back: offer held high, B must be taken in A's done cycle.
    load_valid   = 1'b1;
    data_reg_out = BLK_A;
    tx_ready     = 1'b1;
    settle();
    chk("b2b_a_ready", load_ready, 1);
    edge_();
    data_reg_out = BLK_B;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      settle();
      if (tx_done) begin
        chk("b2b_lrdy_at_done", load_ready, 1);
        got = 1;
      end else if (tx_valid) begin
        chk("b2b_lrdy_in_send", load_ready, 0);
      end
      edge_();
    end
    chk("b2b_done_seen", got, 1);
    load_valid = 1'b0;
    settle();
    chk("b2b_b_first_valid", tx_valid, 1);
    chk("b2b_b_first_data", tx_data, 8'hF0);
    edge_();
    wait_idle(40);

    // Load offered while busy must be ignored.
    load_blk(BLK_A);
    for (int i = 0; i < 5; i++) begin settle(); edge_(); end
    load_valid   = 1'b1;
    data_reg_out = '1;
    settle();
    chk("busy_load_ready", load_ready, 0);
    edge_();
    load_valid = 1'b0;
    wait_idle(40);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("busy_nothing_captured", tx_valid, 0);
      edge_();
    end

    // Reset after beat 7 aborts the block; a fresh load then streams from beat 0.
    load_blk(BLK_C);
    for (int i = 0; i < 7; i++) begin settle(); edge_(); end
    rst = 1'b1;
    settle();
    edge_();
    rst = 1'b0;
    settle();
    chk("mid_rst_load_ready", load_ready, 1);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_last", tx_last, 0);
    chk("mid_rst_tx_done", tx_done, 0);
    chk("mid_rst_busy", busy, 0);
    edge_();
    for (int i = 0; i < 3; i++) begin settle(); edge_(); end
    load_blk(BLK_D);
    settle();
    chk("post_rst_first_data", tx_data, 8'hA5);
    edge_();
    wait_idle(40);
    tx_ready = 1'b0;

    // 32-bit beats: four words, most significant first, last on the fourth.
    w_load_valid = 1'b1;
    w_data       = BLK_A;
    w_tx_ready   = 1'b1;
    settle();
    chk("w_load_ready", w_load_ready, 1);
    edge_();
    w_load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("w_valid_%0d", k), w_tx_valid, 1);
      chk($sformatf("w_data_%0d", k), w_tx_data, wexp[k]);
      chk($sformatf("w_last_%0d", k), w_tx_last, (k == 3) ? 1 : 0);
      edge_();
    end
    settle();
    chk("w_done", w_tx_done, 1);
    chk("w_valid_after", w_tx_valid, 0);
    chk("w_load_ready_after", w_load_ready, 1);
    edge_();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
